// File: rtl/fir_mac_sequencer.sv
// Time-multiplexed FIR: one accepted sample -> TAPS single-MAC cycles over a circular
// history, coefficients fetched from an external combinational LUT via coef_addr.
module fir_mac_sequencer #(
  parameter int TAPS       = 64,
  parameter int DATA_WIDTH = 16,
  parameter int ACC_WIDTH  = 2*DATA_WIDTH + $clog2(TAPS)
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         flush,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic signed [DATA_WIDTH-1:0] in_data,
  output logic [$clog2(TAPS)-1:0]      coef_addr,
  input  logic signed [DATA_WIDTH-1:0] coef_data,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic signed [ACC_WIDTH-1:0]  out_data
);

  localparam int AW = $clog2(TAPS);
  localparam int PW = 2*DATA_WIDTH;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MAC  = 2'd1,
    S_DONE = 2'd2
  } state_e;

  state_e                        state_q, state_d;
  logic [AW-1:0]                 head_q, head_d;
  logic [AW-1:0]                 k_q, k_d;
  logic signed [ACC_WIDTH-1:0]   acc_q, acc_d;
  logic signed [DATA_WIDTH-1:0]  hist_q [TAPS];
  logic signed [DATA_WIDTH-1:0]  hist_d [TAPS];
  logic [AW-1:0]                 rd_idx_s;
  logic signed [PW-1:0]          prod_s;

  function automatic logic signed [ACC_WIDTH-1:0] sext_prod(input logic signed [PW-1:0] p);
    sext_prod = {{(ACC_WIDTH-PW){p[PW-1]}}, p};
  endfunction

  // Tap k reads the sample k steps older than head; the AW-bit subtraction wraps mod TAPS.
  assign rd_idx_s = head_q - k_q;
  assign prod_s   = coef_data * hist_q[rd_idx_s];

  assign in_ready  = (state_q == S_IDLE);
  assign out_valid = (state_q == S_DONE);
  assign out_data  = acc_q;
  assign coef_addr = (state_q == S_MAC) ? k_q : '0;

  // Next-state, history write and accumulate; flush overrides everything.
  always_comb begin
    state_d = state_q;
    head_d  = head_q;
    k_d     = k_q;
    acc_d   = acc_q;
    hist_d  = hist_q;
    if (flush) begin
      hist_d  = '{default: '0};
      head_d  = '0;
      k_d     = '0;
      acc_d   = '0;
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (in_valid) begin
            head_d         = head_q + AW'(1);
            hist_d[head_d] = in_data;
            k_d            = '0;
            acc_d          = '0;
            state_d        = S_MAC;
          end else begin
            state_d = S_IDLE;
          end
        end
        S_MAC: begin
          acc_d = acc_q + sext_prod(prod_s);
          k_d   = k_q + AW'(1);
          if (k_q == AW'(TAPS-1)) begin
            state_d = S_DONE;
          end else begin
            state_d = S_MAC;
          end
        end
        S_DONE: begin
          if (out_ready) begin
            state_d = S_IDLE;
          end else begin
            state_d = S_DONE;
          end
        end
        default: begin
          state_d = S_IDLE;
        end
      endcase
    end
  end

  // State registers with asynchronous clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      head_q  <= '0;
      k_q     <= '0;
      acc_q   <= '0;
      hist_q  <= '{default: '0};
    end else begin
      state_q <= state_d;
      head_q  <= head_d;
      k_q     <= k_d;
      acc_q   <= acc_d;
      hist_q  <= hist_d;
    end
  end

endmodule

// File: tb/tb_fir_mac_sequencer.sv
// Directed bench for fir_mac_sequencer: shift-register reference model feeds a result
// scoreboard; latency, backpressure, flush and async reset behaviour are checked inline.
module tb_fir_mac_sequencer;

  localparam int TAPS = 64;
  localparam int DW   = 16;
  localparam int AW   = 6;
  localparam int ACCW = 2*DW + AW;

  logic                   clk = 1'b0;
  logic                   rst_n;
  logic                   flush;
  logic                   in_valid;
  logic                   in_ready;
  logic signed [DW-1:0]   in_data;
  logic [AW-1:0]          coef_addr;
  logic signed [DW-1:0]   coef_data;
  logic                   out_valid;
  logic                   out_ready;
  logic signed [ACCW-1:0] out_data;

  logic signed [DW-1:0]   lut [TAPS];
  logic signed [DW-1:0]   mh  [TAPS];
  logic signed [ACCW-1:0] sb [$];
  logic signed [ACCW-1:0] last_y;
  int checks = 0;
  int errors = 0;

  fir_mac_sequencer #(.TAPS(TAPS), .DATA_WIDTH(DW), .ACC_WIDTH(ACCW)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .coef_addr(coef_addr), .coef_data(coef_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data)
  );

  assign coef_data = lut[coef_addr];

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic signed [63:0] obs, input logic signed [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic model_clear();
    for (int i = 0; i < TAPS; i++) mh[i] = '0;
  endtask

  // Reference: mh[k] holds x[n-k]; y = sum lut[k]*mh[k] in 64-bit arithmetic.
  task automatic model_push(input logic signed [DW-1:0] x);
    longint s;
    for (int i = TAPS-1; i > 0; i--) mh[i] = mh[i-1];
    mh[0] = x;
    s = 0;
    for (int k = 0; k < TAPS; k++) s += longint'(lut[k]) * longint'(mh[k]);
    sb.push_back(s[ACCW-1:0]);
  endtask

  task automatic do_flush();
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    model_clear();
  endtask

  // One sample from a negedge: accept, wait for result, optional hold or mid-MAC flush.
  task automatic run_sample(input logic signed [DW-1:0] x, input int hold, input int flush_at);
    int c;
    bit seen;
    logic signed [ACCW-1:0] exp_y, held;
    check("in_ready_before_accept", in_ready, 64'sd1);
    in_valid = 1'b1;
    in_data  = x;
    if (hold > 0) out_ready = 1'b0;
    @(posedge clk);
    model_push(x);
    @(negedge clk);
    in_valid = 1'b0;
    in_data  = '0;
    c = 0;
    if (flush_at >= 0) begin
      while (c < flush_at) begin @(negedge clk); c++; end
      check("coef_addr_at_flush", coef_addr, 64'(flush_at));
      flush    = 1'b1;
      in_valid = 1'b1;
      in_data  = 16'sd1234;
      @(negedge clk);
      flush    = 1'b0;
      in_valid = 1'b0;
      in_data  = '0;
      check("flush_in_ready", in_ready, 64'sd1);
      check("flush_out_valid", out_valid, 64'sd0);
      check("flush_coef_addr", coef_addr, 64'sd0);
      if (sb.size() > 0) void'(sb.pop_back());
      model_clear();
      seen = 1'b0;
      repeat (70) begin @(negedge clk); if (out_valid !== 1'b0) seen = 1'b1; end
      check("flush_no_output", seen, 64'sd0);
      return;
    end
    while (out_valid !== 1'b1 && c < 200) begin @(negedge clk); c++; end
    check("latency", c, 64'(TAPS));
    exp_y = (sb.size() > 0) ? sb.pop_front() : 'x;
    check("out_data", out_data, exp_y);
    last_y = out_data;
    if (hold > 0) begin
      held     = out_data;
      in_valid = 1'b1;
      in_data  = 16'sd77;
      repeat (hold) begin
        @(negedge clk);
        check("hold_data", out_data, held);
        check("hold_valid", out_valid, 64'sd1);
        check("hold_in_ready", in_ready, 64'sd0);
      end
      in_valid  = 1'b0;
      in_data   = '0;
      out_ready = 1'b1;
    end
    @(negedge clk);
    check("post_hs_in_ready", in_ready, 64'sd1);
    check("post_hs_out_valid", out_valid, 64'sd0);
  endtask

  initial begin
    int c;
    rst_n     = 1'b0;
    flush     = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b1;
    for (int k = 0; k < TAPS; k++) lut[k] = DW'(k + 1);
    model_clear();
    repeat (2) @(negedge clk);
    check("rst_in_ready", in_ready, 64'sd1);
    check("rst_out_valid", out_valid, 64'sd0);
    check("rst_out_data", out_data, 64'sd0);
    check("rst_coef_addr", coef_addr, 64'sd0);
    rst_n = 1'b1;
    @(negedge clk);

    // impulse response 1..64
    for (int i = 0; i < TAPS; i++) run_sample((i == 0) ? 16'sd1 : 16'sd0, 0, -1);

    // backpressure, offered sample during hold must be ignored
    run_sample(16'sd5, 10, -1);
    run_sample(16'sd0, 0, -1);

    // flush mid-MAC, then fresh impulse
    run_sample(16'sd9, 0, 20);
    for (int i = 0; i < 16; i++) run_sample((i == 0) ? 16'sd1 : 16'sd0, 0, -1);

    // step and wrap
    do_flush();
    for (int k = 0; k < TAPS; k++) lut[k] = 16'sd1;
    for (int i = 0; i < 130; i++) run_sample(16'sd3, 0, -1);
    check("step_final", last_y, 64'sd192);

    // extremes
    do_flush();
    for (int k = 0; k < TAPS; k++) lut[k] = -16'sd32768;
    for (int i = 0; i < TAPS; i++) run_sample(-16'sd32768, 0, -1);
    check("extreme_pos", last_y, 64'sd68719476736);
    do_flush();
    for (int k = 0; k < TAPS; k++) lut[k] = 16'sd32767;
    for (int i = 0; i < TAPS; i++) run_sample(-16'sd32768, 0, -1);
    check("extreme_neg", last_y, -64'sd68717379584);

    // async reset while in DONE
    for (int k = 0; k < TAPS; k++) lut[k] = DW'(k + 1);
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = 16'sd42;
    @(posedge clk);
    model_push(16'sd42);
    @(negedge clk);
    in_valid = 1'b0;
    in_data  = '0;
    c = 0;
    while (out_valid !== 1'b1 && c < 200) begin @(negedge clk); c++; end
    check("rst_test_done", out_valid, 64'sd1);
    #2 rst_n = 1'b0;
    #1;
    check("arst_out_valid", out_valid, 64'sd0);
    check("arst_in_ready", in_ready, 64'sd1);
    check("arst_coef_addr", coef_addr, 64'sd0);
    if (sb.size() > 0) void'(sb.pop_back());
    model_clear();
    out_ready = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 16; i++) run_sample((i == 0) ? 16'sd1 : 16'sd0, 0, -1);

    check("scoreboard_empty", sb.size(), 64'sd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/fir_mac_sequencer.md
# fir_mac_sequencer

Sequences the FIR coefficient lookup table (`coef_lut`) and a local circular sample history to compute one filter output per accepted input sample. It uses a single multiply-accumulate over TAPS cycles. It sits between the upstream sample source and the downstream result consumer, with valid/ready handshakes on both sides. It drives the LUT address and consumes the LUT's combinational read data.

## Interface
- `TAPS`, 64, number of filter taps; must equal the LUT `STACK_SIZE`; power of two, at least 2
- `DATA_WIDTH`, 16, width of samples and coefficients (two's complement)
- `ACC_WIDTH`, 2*DATA_WIDTH+$clog2(TAPS), accumulator and output width
- `clk`  in  1  single clock; all state updates on the rising edge
- `rst_n`  in  1  asynchronous, active-low reset
- `flush`  in  1  synchronous clear of history and sequencing
- `in_valid`  in  1  upstream sample valid
- `in_ready`  out  1  block can accept a sample
- `in_data`  in  DATA_WIDTH  signed input sample x[n]
- `coef_addr`  out  $clog2(TAPS)  LUT address
- `coef_data`  in  DATA_WIDTH  signed LUT read data; combinational, valid in the same cycle as `coef_addr`
- `out_valid`  out  1  result valid
- `out_ready`  in  1  downstream accepts result
- `out_data`  out  ACC_WIDTH  signed y[n]

## Operation
- Computes y[n] = sum over k = 0..TAPS-1 of h[k]*x[n-k], where h[k] = LUT[k].
- x[m] = 0 for any sample preceding the last reset or flush.
- History is a TAPS-entry register array, circular, newest-sample pointer `head`.
- FSM states:
  - IDLE: `in_ready`=1. On `in_valid`, the sample is accepted: `head` <= (head+1) mod TAPS, the sample is written at the new head, `k` <= 0, `acc` <= 0, go to MAC.
  - MAC: `coef_addr`=k. Each edge: acc <= acc + sext(coef_data * hist[(head-k) mod TAPS]); k <= k+1. After the edge with k=TAPS-1, go to DONE.
  - DONE: `out_valid`=1, `out_data`=acc. On `out_valid && out_ready`, go to IDLE.
- Arithmetic:
  - Signed DATA_WIDTH x DATA_WIDTH product is full 2*DATA_WIDTH bits, sign-extended to ACC_WIDTH.
  - No rounding, saturation or truncation; the default ACC_WIDTH cannot overflow.
- `coef_addr` = 0 outside MAC.
- `in_ready` is 0 in MAC and DONE. No sample is accepted during a computation.
- `head` and `k` wrap modulo TAPS. History continues seamlessly after more than TAPS samples.
- `flush` (synchronous, highest priority, any state):
  - history is zeroed, head and k <= 0, acc <= 0, state <= IDLE;
  - a result pending in DONE is discarded;
  - `in_valid` in the flush cycle is ignored (not accepted).
- `rst_n` low (asynchronous, any time, including mid-MAC or in DONE): same clearing as flush, immediately.
- Reset values: `in_ready`=1, `out_valid`=0, `out_data`=0, `coef_addr`=0; state IDLE, history 0, head 0, k 0.

## Timing
- Accept edge E0 (IDLE, in_valid and in_ready both 1). The MAC occupies the cycles after E0.
- Accumulation edges are E1..E_TAPS.
- `out_valid` rises after E_TAPS: latency is TAPS cycles from acceptance to valid result.
- `out_data` and `out_valid` are stable while `out_ready`=0; DONE holds indefinitely.
- Handshake at edge Ed returns to IDLE. `in_ready`=1 in the following cycle; `out_valid`=0 in that cycle.
- Minimum sample period is TAPS+2 cycles: accept, TAPS MAC cycles, 1 DONE cycle with `out_ready`=1.
- `out_ready` is ignored outside DONE. `in_valid` is ignored outside IDLE.
- All outputs are registered-state derived. `coef_addr` is a direct function of the k register.

## Test plan
- Impulse: LUT h[k]=k+1; send 1 then 63 zeros, `out_ready`=1 -> outputs 1,2,...,64 in order. Each out_valid comes exactly 64 cycles after its accept edge; `in_ready` returns 1 exactly 66 cycles after the previous accept edge.
- Step and wrap: h[k]=1; send 130 samples of value 3 -> y ramps 3,6,...,192, then stays at 192 for samples 64..130.
- Extremes: all h=-32768, all x=-32768, 64 samples -> final y = 68719476736 (2^36), with no sign error. Separately h=32767 and x=-32768 -> y[63] = -68717379584.
- Backpressure: hold `out_ready`=0 for 10 cycles in DONE -> `out_data` is constant, `out_valid`=1, `in_ready`=0, and an offered `in_valid` is not accepted. Releasing `out_ready` gives the handshake, then `in_ready`=1 on the next cycle.
- Flush mid-MAC at k=20 (pulse with `in_valid`=1) -> no output appears, `in_ready`=1 next cycle, and the offered sample is not accepted. A following impulse reproduces the fresh-history impulse response.
- Async reset: drop `rst_n` mid-cycle while in DONE -> `out_valid`=0, `in_ready`=1 and `coef_addr`=0 immediately, without waiting for a clock edge. History is zeroed, verified by the impulse response afterwards.
